psum_drain: RTL

Downstream consumer of the PE output FIFO. It pops 3×6 partial-sum words from the PE, accumulates them across input channels in a local accumulation buffer, and requantizes the final sums to 8 bit. It then hands each finished 18-byte output word to the activation write-back path through a valid/ready handshake.

---
 rtl/diff_demo_pkg.sv | 16 +
 rtl/psum_requant.sv | 42 ++++
 rtl/psum_drain.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/diff_demo_pkg.sv
// Shared types and widths for the PE partial-sum drain path.
package diff_demo_pkg;

  localparam int unsigned PSUM_WIDTH    = 16;
  localparam int unsigned ACC_WIDTH_DEF = 32;
  localparam int unsigned NUM_LANES     = 18;
  localparam int unsigned OUT_WIDTH     = 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_t;

  // Role of a channel within the accumulation; ONLY means first and last at once.
  typedef enum logic [1:0] {CLS_FIRST, CLS_MID, CLS_LAST, CLS_ONLY} ch_class_t;

  typedef logic [NUM_LANES-1:0][ACC_WIDTH_DEF-1:0] acc_word_t;

endpackage

// File: rtl/psum_requant.sv
// One lane of requantization: round half up, arithmetic shift, saturate to int8.
// Optional ReLU clamp when PSUM_DRAIN_RELU_EN is defined.
module psum_requant
  import diff_demo_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0]  i_sum,
  input  logic [4:0]            i_shift,
  output logic [OUT_WIDTH-1:0]  o_q_c
);

  localparam int unsigned EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] MAX_V = EW'(127);
  localparam logic signed [EW-1:0] MIN_V = EW'(-128);

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_biased;
  logic signed [EW-1:0] w_shr;

  // One extra bit keeps the rounding bias from overflowing the lane.
  assign w_ext    = EW'(signed'(i_sum));
  assign w_rnd    = (i_shift == 5'd0) ? '0 : (EW'(1) << (i_shift - 5'd1));
  assign w_biased = w_ext + w_rnd;
  assign w_shr    = w_biased >>> i_shift;

  always_comb begin
    o_q_c = w_shr[OUT_WIDTH-1:0];
    if (w_shr > MAX_V) begin
      o_q_c = 8'h7f;
    end else if (w_shr < MIN_V) begin
      o_q_c = 8'h80;
    end
`ifdef PSUM_DRAIN_RELU_EN
    if (w_shr < 0) begin
      o_q_c = '0;
    end
`endif
  end

endmodule

// File: rtl/psum_drain.sv
// Pops PE partial sums, accumulates across channels, requantizes the last channel to int8.
// Build option PSUM_DRAIN_RELU_EN clamps negative outputs to zero.
module psum_drain
  import diff_demo_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned ACC_DEPTH = 64,
  parameter int unsigned ADDR_W    = $clog2(ACC_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [7:0]                      cfg_num_ch_i,
  input  logic [ADDR_W:0]                 cfg_num_words_i,
  input  logic [4:0]                      cfg_shift_i,
  input  logic [NUM_LANES*PSUM_WIDTH-1:0] fifo_dout_i,
  input  logic                            fifo_empty_i,
  output logic                            fifo_rd_en_o,
  output logic [NUM_LANES*OUT_WIDTH-1:0]  out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o,
  output logic                            done_o
);

  drain_state_t                     r_state;
  logic [7:0]                       r_num_ch;
  logic [ADDR_W:0]                  r_num_words;
  logic [4:0]                       r_shift;
  logic [7:0]                       r_ch_idx;
  logic [ADDR_W-1:0]                r_word_idx;
  logic                             r_inflight;
  logic [ADDR_W-1:0]                r_if_addr;
  ch_class_t                        r_if_cls;
  logic [NUM_LANES*OUT_WIDTH-1:0]   r_out_data;
  logic                             r_out_valid;
  logic                             r_busy;
  logic                             r_done;

  logic [NUM_LANES-1:0][ACC_WIDTH-1:0] r_acc [ACC_DEPTH];

  logic                                w_last_word;
  logic                                w_last_ch;
  logic                                w_first_ch;
  ch_class_t                           w_cls;
  logic                                w_rd_en;
  logic                                w_if_final;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0] w_acc_rd;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0] w_acc_wr;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0] w_final;
  logic [NUM_LANES*OUT_WIDTH-1:0]      w_q;

  assign w_last_word = ({1'b0, r_word_idx} == (r_num_words - (ADDR_W+1)'(1)));
  assign w_last_ch   = (r_ch_idx == (r_num_ch - 8'd1));
  assign w_first_ch  = (r_ch_idx == 8'd0);

  always_comb begin
    w_cls = CLS_MID;
    if (w_last_ch && w_first_ch) begin
      w_cls = CLS_ONLY;
    end else if (w_last_ch) begin
      w_cls = CLS_LAST;
    end else if (w_first_ch) begin
      w_cls = CLS_FIRST;
    end
  end

  // Last-channel reads wait until the output register and the read pipe are empty.
  assign w_rd_en = (r_state == RUN) && !fifo_empty_i &&
                   (!w_last_ch || (!r_out_valid && !r_inflight));

  assign w_if_final = r_inflight && ((r_if_cls == CLS_LAST) || (r_if_cls == CLS_ONLY));
  assign w_acc_rd   = r_acc[r_if_addr];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [ACC_WIDTH-1:0] w_psum_ext;
    logic [ACC_WIDTH-1:0] w_acc_sum;

    assign w_psum_ext  = ACC_WIDTH'(signed'(fifo_dout_i[k*PSUM_WIDTH +: PSUM_WIDTH]));
    assign w_acc_sum   = w_acc_rd[k] + w_psum_ext;
    assign w_acc_wr[k] = (r_if_cls == CLS_FIRST) ? w_psum_ext : w_acc_sum;
    assign w_final[k]  = (r_if_cls == CLS_ONLY) ? w_psum_ext : w_acc_sum;

    psum_requant #(.ACC_WIDTH(ACC_WIDTH)) u_requant (
      .i_sum   (w_final[k]),
      .i_shift (r_shift),
      .o_q_c   (w_q[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Accumulation buffer: no reset, the first channel always overwrites.
  always_ff @(posedge clk) begin
    if (r_inflight && ((r_if_cls == CLS_FIRST) || (r_if_cls == CLS_MID))) begin
      r_acc[r_if_addr] <= w_acc_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_num_ch    <= '0;
      r_num_words <= '0;
      r_shift     <= '0;
      r_ch_idx    <= '0;
      r_word_idx  <= '0;
      r_inflight  <= 1'b0;
      r_if_addr   <= '0;
      r_if_cls    <= CLS_FIRST;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_rd_en;

      if (w_rd_en) begin
        r_if_addr <= r_word_idx;
        r_if_cls  <= w_cls;
        if (w_last_word) begin
          r_word_idx <= '0;
          r_ch_idx   <= w_last_ch ? 8'd0 : (r_ch_idx + 8'd1);
        end else begin
          r_word_idx <= r_word_idx + ADDR_W'(1);
        end
      end

      if (w_if_final) begin
        r_out_data  <= w_q;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_num_ch    <= (cfg_num_ch_i == 8'd0) ? 8'd1 : cfg_num_ch_i;
            r_num_words <= cfg_num_words_i;
            r_shift     <= cfg_shift_i;
            r_ch_idx    <= '0;
            r_word_idx  <= '0;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_rd_en && w_last_ch && w_last_word) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          // Leave as the final word is accepted so done lands one cycle after the handshake.
          if (!r_inflight && (!r_out_valid || out_ready_i)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en_o = w_rd_en;
  assign out_data_o   = r_out_data;
  assign out_valid_o  = r_out_valid;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule
